// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I decode stage.
// Holds the ALU control codes, the opcode/funct3/funct7 values the decoder
// recognises, the branch condition codes and the decoded-word struct that
// the output buffer stores.
package alu_pkg;

    // ALU operation select (3-bit ALUControl)
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 values for ALU operations
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct3 for word-sized loads and stores
    localparam logic [2:0] F3_WORD = 3'b010;

    // funct3 values for conditional branches
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Branch condition evaluated against the ALU flags
    localparam logic [1:0] BR_EQ = 2'b00;  // taken when Zero = 1
    localparam logic [1:0] BR_NE = 2'b01;  // taken when Zero = 0
    localparam logic [1:0] BR_LT = 2'b10;  // taken when sign_flag = 1
    localparam logic [1:0] BR_GE = 2'b11;  // taken when sign_flag = 0

    // Decoded control word, one per buffer entry
    typedef struct packed {
        logic [2:0]  alu_ctrl;
        logic        alu_src_b;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch_en;
        logic [1:0]  branch_type;
    } alu_decode_t;

    // Sign-extend a 12-bit I/S immediate
    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

    // Sign-extend a 13-bit B immediate (bit 0 is always zero)
    function automatic logic [31:0] sext13(input logic [12:0] v);
        return {{19{v[12]}}, v};
    endfunction

endpackage

// File: rtl/alu_decode_stage_if.sv
// Bus between fetch, the decode stage and the execute datapath.
// Optional macro ALU_DECODE_ILLEGAL_FLAG_EN adds the illegal flag to the
// output side.
//
// Handshake: on both sides a transfer happens on a rising clk edge where
// valid and ready are both 1. A producer holding valid keeps its payload
// stable until the transfer; ready may change freely and never depends
// combinationally on valid from the same side.
interface alu_decode_stage_if;

    // Fetch side
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;

    // Execute side
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  alu_ctrl;
    logic        alu_src_b;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch_en;
    logic [1:0]  branch_type;
`ifdef ALU_DECODE_ILLEGAL_FLAG_EN
    logic        illegal;
`endif

`ifdef ALU_DECODE_ILLEGAL_FLAG_EN
    // Environment view: drives instructions, consumes decoded words
    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, alu_ctrl, alu_src_b, imm, rs1, rs2, rd,
               reg_write, mem_read, mem_write, branch_en, branch_type, illegal
    );

    // Decode stage view
    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, alu_ctrl, alu_src_b, imm, rs1, rs2, rd,
               reg_write, mem_read, mem_write, branch_en, branch_type, illegal
    );
`else
    // Environment view: drives instructions, consumes decoded words
    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, alu_ctrl, alu_src_b, imm, rs1, rs2, rd,
               reg_write, mem_read, mem_write, branch_en, branch_type
    );

    // Decode stage view
    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, alu_ctrl, alu_src_b, imm, rs1, rs2, rd,
               reg_write, mem_read, mem_write, branch_en, branch_type
    );
`endif

endinterface

// File: rtl/alu_decode_comb.sv
// Purely combinational RV32I decoder: raw instruction word in, control
// word plus an illegal bit out. Any word outside the supported subset
// yields an all-zero control word (alu_ctrl = add, every enable low).
module alu_decode_comb
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output alu_decode_t dec,
    output logic        illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_shamt;
    logic        legal;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign imm_i     = sext12(instr[31:20]);
    assign imm_s     = sext12({instr[31:25], instr[11:7]});
    assign imm_b     = sext13({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
    assign imm_shamt = {27'b0, instr[24:20]};

    // Decode opcode/funct fields into the control word and legality
    always_comb begin
        dec       = '0;
        legal     = 1'b0;
        dec.rs1   = instr[19:15];
        dec.rs2   = instr[24:20];
        dec.rd    = instr[11:7];

        case (opcode)
            OPC_OP: begin
                dec.alu_src_b = 1'b0;
                dec.reg_write = 1'b1;
                case (funct3)
                    F3_ADD_SUB: begin
                        if (funct7 == F7_BASE) begin
                            legal        = 1'b1;
                            dec.alu_ctrl = ALU_ADD;
                        end else if (funct7 == F7_ALT) begin
                            legal        = 1'b1;
                            dec.alu_ctrl = ALU_SUB;
                        end
                    end
                    F3_SLL: begin
                        legal        = (funct7 == F7_BASE);
                        dec.alu_ctrl = ALU_SLL;
                    end
                    F3_XOR: begin
                        legal        = (funct7 == F7_BASE);
                        dec.alu_ctrl = ALU_XOR;
                    end
                    F3_SRL: begin
                        // funct7 = 0100000 would be sra, which this ALU lacks
                        legal        = (funct7 == F7_BASE);
                        dec.alu_ctrl = ALU_SRL;
                    end
                    F3_OR: begin
                        legal        = (funct7 == F7_BASE);
                        dec.alu_ctrl = ALU_OR;
                    end
                    F3_AND: begin
                        legal        = (funct7 == F7_BASE);
                        dec.alu_ctrl = ALU_AND;
                    end
                    default: legal = 1'b0;  // slt / sltu
                endcase
            end

            OPC_OP_IMM: begin
                dec.alu_src_b = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm       = imm_i;
                case (funct3)
                    F3_ADD_SUB: begin
                        legal        = 1'b1;
                        dec.alu_ctrl = ALU_ADD;
                    end
                    F3_SLL: begin
                        legal        = (funct7 == F7_BASE);
                        dec.alu_ctrl = ALU_SLL;
                        dec.imm      = imm_shamt;
                    end
                    F3_XOR: begin
                        legal        = 1'b1;
                        dec.alu_ctrl = ALU_XOR;
                    end
                    F3_SRL: begin
                        // srai (imm[11:5] = 0100000) is not supported
                        legal        = (funct7 == F7_BASE);
                        dec.alu_ctrl = ALU_SRL;
                        dec.imm      = imm_shamt;
                    end
                    F3_OR: begin
                        legal        = 1'b1;
                        dec.alu_ctrl = ALU_OR;
                    end
                    F3_AND: begin
                        legal        = 1'b1;
                        dec.alu_ctrl = ALU_AND;
                    end
                    default: legal = 1'b0;  // slti / sltiu
                endcase
            end

            OPC_LOAD: begin
                legal         = (funct3 == F3_WORD);
                dec.alu_ctrl  = ALU_ADD;
                dec.alu_src_b = 1'b1;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm       = imm_i;
            end

            OPC_STORE: begin
                legal         = (funct3 == F3_WORD);
                dec.alu_ctrl  = ALU_ADD;
                dec.alu_src_b = 1'b1;
                dec.mem_write = 1'b1;
                dec.imm       = imm_s;
            end

            OPC_BRANCH: begin
                dec.alu_ctrl  = ALU_SUB;
                dec.alu_src_b = 1'b0;
                dec.branch_en = 1'b1;
                dec.imm       = imm_b;
                case (funct3)
                    F3_BEQ: begin
                        legal           = 1'b1;
                        dec.branch_type = BR_EQ;
                    end
                    F3_BNE: begin
                        legal           = 1'b1;
                        dec.branch_type = BR_NE;
                    end
                    F3_BLT: begin
                        legal           = 1'b1;
                        dec.branch_type = BR_LT;
                    end
                    F3_BGE: begin
                        legal           = 1'b1;
                        dec.branch_type = BR_GE;
                    end
                    default: legal = 1'b0;  // bltu / bgeu / reserved
                endcase
            end

            default: legal = 1'b0;
        endcase

        // Illegal words must not enable anything downstream
        if (!legal) begin
            dec = '0;
        end
        illegal = ~legal;
    end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered RV32I decode stage with a 2-entry output buffer.
// Optional macro ALU_DECODE_ILLEGAL_FLAG_EN: when defined, illegal words are
// buffered and emitted with the illegal flag set; when undefined they are
// accepted from fetch and silently dropped.
module alu_decode_stage
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    alu_decode_stage_if.slave   bus
);

    alu_decode_t dec_word;
    logic        dec_illegal;

    // Buffer: entry0 is always the head, entry1 the second slot
    alu_decode_t entry0;
    alu_decode_t entry1;
    logic [1:0]  count;

    logic        push_ok;
    logic        push;
    logic        pop;
    logic        in_ready;
    logic        out_valid;

    alu_decode_comb u_decode (
        .instr   (bus.in_instr),
        .dec     (dec_word),
        .illegal (dec_illegal)
    );

`ifdef ALU_DECODE_ILLEGAL_FLAG_EN
    logic ill0;
    logic ill1;

    assign push_ok = 1'b1;
`else
    // Illegal words are consumed from fetch but never enter the buffer
    assign push_ok = ~dec_illegal;
`endif

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = bus.in_valid & in_ready & push_ok;
    assign pop       = out_valid & bus.out_ready;

    // FIFO update: append at the tail, shift forward on pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        entry0 <= dec_word;
                    end else begin
                        entry1 <= dec_word;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    // Push implies count < 2, so with a pop count is 1 here
                    // and the new word becomes the head directly.
                    entry0 <= (count == 2'd1) ? dec_word : entry1;
                    entry1 <= dec_word;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_DECODE_ILLEGAL_FLAG_EN
    // Illegal flags travel alongside the decoded entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill0 <= 1'b0;
            ill1 <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        ill0 <= dec_illegal;
                    end else begin
                        ill1 <= dec_illegal;
                    end
                end
                2'b01: ill0 <= ill1;
                2'b11: begin
                    ill0 <= (count == 2'd1) ? dec_illegal : ill1;
                    ill1 <= dec_illegal;
                end
                default: ;
            endcase
        end
    end

    assign bus.illegal = ill0;
`endif

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.alu_ctrl    = entry0.alu_ctrl;
    assign bus.alu_src_b   = entry0.alu_src_b;
    assign bus.imm         = entry0.imm;
    assign bus.rs1         = entry0.rs1;
    assign bus.rs2         = entry0.rs2;
    assign bus.rd          = entry0.rd;
    assign bus.reg_write   = entry0.reg_write;
    assign bus.mem_read    = entry0.mem_read;
    assign bus.mem_write   = entry0.mem_write;
    assign bus.branch_en   = entry0.branch_en;
    assign bus.branch_type = entry0.branch_type;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage.
// Builds with or without ALU_DECODE_ILLEGAL_FLAG_EN.
module tb_alu_decode_stage;

    // Packed word: {alu_ctrl, alu_src_b, imm, rs1, rs2, rd,
    //               reg_write, mem_read, mem_write, branch_en, branch_type, illegal}
    localparam int W = 58;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_decode_stage_if bus ();

    alu_decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] msk_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] observed();
        logic ill;
        ill = 1'b0;
`ifdef ALU_DECODE_ILLEGAL_FLAG_EN
        ill = bus.illegal;
`endif
        return {bus.alu_ctrl, bus.alu_src_b, bus.imm, bus.rs1, bus.rs2, bus.rd,
                bus.reg_write, bus.mem_read, bus.mem_write, bus.branch_en,
                bus.branch_type, ill};
    endfunction

    // Reference decoder: expected word, compare mask, and whether it is emitted
    function automatic void model(input logic [31:0] i, output logic [W-1:0] w,
                                  output logic [W-1:0] m, output logic emit);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ok;
        logic [2:0]  ac;
        logic        srcb, rw, mr, mw, be;
        logic [1:0]  bt;
        logic [31:0] im;
        logic [12:0] boff;
        op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        ok = 1'b0; ac = 3'd0; srcb = 1'b0; rw = 1'b0; mr = 1'b0; mw = 1'b0;
        be = 1'b0; bt = 2'd0; im = 32'd0;
        m = '1;
        if (op == 7'h33) begin
            rw = 1'b1;
            m[53:22] = '0;
            if (f3 == 3'd0 && f7 == 7'h00) begin ok = 1'b1; ac = 3'b000; end
            else if (f3 == 3'd0 && f7 == 7'h20) begin ok = 1'b1; ac = 3'b010; end
            else if (f7 == 7'h00 && f3 == 3'd1) begin ok = 1'b1; ac = 3'b001; end
            else if (f7 == 7'h00 && f3 == 3'd4) begin ok = 1'b1; ac = 3'b100; end
            else if (f7 == 7'h00 && f3 == 3'd5) begin ok = 1'b1; ac = 3'b101; end
            else if (f7 == 7'h00 && f3 == 3'd6) begin ok = 1'b1; ac = 3'b110; end
            else if (f7 == 7'h00 && f3 == 3'd7) begin ok = 1'b1; ac = 3'b111; end
        end else if (op == 7'h13) begin
            rw = 1'b1; srcb = 1'b1;
            m[16:12] = '0;
            im = {{20{i[31]}}, i[31:20]};
            if (f3 == 3'd1 || f3 == 3'd5) begin
                ok = (f7 == 7'h00);
                ac = (f3 == 3'd1) ? 3'b001 : 3'b101;
                im = {27'd0, i[24:20]};
            end else if (f3 != 3'd2 && f3 != 3'd3) begin
                ok = 1'b1;
                ac = f3 == 3'd0 ? 3'b000 : f3 == 3'd4 ? 3'b100 : f3 == 3'd6 ? 3'b110 : 3'b111;
            end
        end else if (op == 7'h03) begin
            ok = (f3 == 3'd2); srcb = 1'b1; mr = 1'b1; rw = 1'b1;
            m[16:12] = '0;
            im = {{20{i[31]}}, i[31:20]};
        end else if (op == 7'h23) begin
            ok = (f3 == 3'd2); srcb = 1'b1; mw = 1'b1;
            m[11:7] = '0;
            im = {{20{i[31]}}, i[31:25], i[11:7]};
        end else if (op == 7'h63) begin
            ac = 3'b010; be = 1'b1;
            m[11:7] = '0;
            boff = {i[31], i[7], i[30:25], i[11:8], 1'b0};
            im = {{19{boff[12]}}, boff};
            case (f3)
                3'd0: begin ok = 1'b1; bt = 2'b00; end
                3'd1: begin ok = 1'b1; bt = 2'b01; end
                3'd4: begin ok = 1'b1; bt = 2'b10; end
                3'd5: begin ok = 1'b1; bt = 2'b11; end
                default: ok = 1'b0;
            endcase
        end
        if (ok) begin
            w = {ac, srcb, im, i[19:15], i[24:20], i[11:7], rw, mr, mw, be, bt, 1'b0};
            emit = 1'b1;
        end else begin
            // only the op select, enables and the flag are pinned for illegal words
            w = '0;
            w[0] = 1'b1;
            m = '0;
            m[57:55] = '1;
            m[6:3] = '1;
            m[0] = 1'b1;
`ifdef ALU_DECODE_ILLEGAL_FLAG_EN
            emit = 1'b1;
`else
            emit = 1'b0;
`endif
        end
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int sel;
        int k;
        r = $urandom();
        sel = $urandom_range(0, 9);
        case (sel)
            0, 1: begin
                r[6:0] = 7'h33;
                k = $urandom_range(0, 3);
                if (k < 2) r[31:25] = 7'h00;
                else if (k == 2) r[31:25] = 7'h20;
            end
            2, 3: begin
                r[6:0] = 7'h13;
                if ($urandom_range(0, 1) == 1) r[31:25] = 7'h00;
            end
            4: begin
                r[6:0] = 7'h03;
                if ($urandom_range(0, 2) != 0) r[14:12] = 3'd2;
            end
            5: begin
                r[6:0] = 7'h23;
                if ($urandom_range(0, 2) != 0) r[14:12] = 3'd2;
            end
            6, 7: r[6:0] = 7'h63;
            default: ;
        endcase
        return r;
    endfunction

    // monitor: pop expected word whenever the DUT hands one over
    logic [W-1:0] mon_e;
    logic [W-1:0] mon_m;
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_m = msk_q.pop_front();
                chk("head_word", observed() & mon_m, mon_e & mon_m);
            end
        end
    end

    // driver: offer one instruction, hold until accepted; in_valid stays high
    task automatic send(input logic [31:0] instr, input bit rand_ready, output int waits);
        logic [W-1:0] e;
        logic [W-1:0] m;
        logic emit;
        model(instr, e, m, emit);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        waits = 0;
        forever begin
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.in_ready) begin
                if (emit) begin
                    exp_q.push_back(e);
                    msk_q.push_back(m);
                end
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            waits++;
            if (waits > 200) begin
                chk("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic drain();
        int n;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    int w;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_fields", observed(), '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // add x3,x1,x2: one-cycle latency and field check
        bus.out_ready = 1'b1;
        send(32'h002081B3, 1'b0, w);
        bus.in_valid = 1'b0;
        chk("add_first_try", 64'(w), 64'd0);
        @(negedge clk);
        chk("add_out_valid", bus.out_valid, 1'b1);
        chk("add_alu_ctrl", bus.alu_ctrl, 3'b000);
        chk("add_regs", {bus.rs1, bus.rs2, bus.rd}, {5'd1, 5'd2, 5'd3});
        chk("add_reg_write", bus.reg_write, 1'b1);
        chk("add_src_b", bus.alu_src_b, 1'b0);
        @(posedge clk); #1;

        // sub x5,x6,x7 then addi x1,x0,-1 back to back
        send(32'h407302B3, 1'b0, w);
        chk("sub_full_rate", 64'(w), 64'd0);
        send(32'hFFF00093, 1'b0, w);
        chk("addi_full_rate", 64'(w), 64'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("addi_alu_ctrl", bus.alu_ctrl, 3'b000);
        chk("addi_imm", bus.imm, 32'hFFFFFFFF);
        chk("addi_src_b", bus.alu_src_b, 1'b1);
        @(posedge clk); #1;

        // beq x1,x2,-4
        send(32'hFE208EE3, 1'b0, w);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("beq_alu_ctrl", bus.alu_ctrl, 3'b010);
        chk("beq_branch", {bus.branch_en, bus.branch_type}, 3'b100);
        chk("beq_imm", bus.imm, 32'hFFFFFFFC);
        chk("beq_reg_write", bus.reg_write, 1'b0);
        @(posedge clk); #1;
        drain();

        // back-pressure: two fit, third waits until a pop
        bus.out_ready = 1'b0;
        send(32'h407302B3, 1'b0, w);
        send(32'h00C5F533, 1'b0, w);
        bus.in_instr = 32'h00209093;
        @(negedge clk);
        chk("full_in_ready", bus.in_ready, 1'b0);
        chk("full_out_valid", bus.out_valid, 1'b1);
        chk("stall_head", bus.alu_ctrl, 3'b010);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_hold", {bus.alu_ctrl, bus.rd}, {3'b010, 5'd5});
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(32'h00209093, 1'b0, w);
        chk("refill_wait", 64'(w), 64'd1);
        drain();

        // slt is outside the supported set
        send(32'h0020A1B3, 1'b0, w);
        bus.in_valid = 1'b0;
        chk("illegal_accepted", 64'(w), 64'd0);
`ifdef ALU_DECODE_ILLEGAL_FLAG_EN
        @(negedge clk);
        chk("illegal_out_valid", bus.out_valid, 1'b1);
        chk("illegal_flag", bus.illegal, 1'b1);
        chk("illegal_ctrl", {bus.alu_ctrl, bus.reg_write, bus.mem_read,
                             bus.mem_write, bus.branch_en}, 7'd0);
        @(posedge clk); #1;
`else
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("illegal_dropped", bus.out_valid, 1'b0);
        end
        @(posedge clk); #1;
`endif
        drain();

        // random mix with random back-pressure
        for (int k = 0; k < 80; k++) begin
            send(rand_instr(), 1'b1, w);
        end
        drain();

        // reset in the middle of a stall
        bus.out_ready = 1'b0;
        send(32'h002081B3, 1'b0, w);
        send(32'hFE208EE3, 1'b0, w);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_in_ready", bus.in_ready, 1'b1);
        chk("midrst_fields", observed(), '0);
        exp_q.delete();
        msk_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_empty", bus.out_valid, 1'b0);
        end
        @(posedge clk); #1;
        send(32'h407302B3, 1'b0, w);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
